// File: rtl/sync_reg_pacer.sv
// Source-domain pacer: buffers register-update bursts in a small FIFO and
// reissues them as single-cycle strobes spaced at least GAP cycles apart.
module sync_reg_pacer #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_stb,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic                       out_strobe,
  output logic [WIDTH-1:0]           out_reg
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned GW = $clog2(GAP + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [GW-1:0]    gcnt;
  logic [GW-1:0]    gcnt_nxt;
  logic             pop;
  logic             push;
  logic             drop;

  // Pop/push decisions and next pointer/gap values; a pop frees a slot for a same-cycle push.
  always_comb begin
    pop        = 1'b0;
    push       = 1'b0;
    drop       = 1'b0;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    gcnt_nxt   = gcnt;

    pop  = (gcnt == '0) && (level != '0);
    push = wr_stb && ((level < LW'(DEPTH)) || pop);
    drop = wr_stb && !push;

    if (pop) begin
      rd_ptr_nxt = rd_ptr + PW'(1);
      gcnt_nxt   = GW'(GAP - 1);
    end else if (gcnt != '0) begin
      gcnt_nxt = gcnt - GW'(1);
    end

    if (push) begin
      wr_ptr_nxt = wr_ptr + PW'(1);
    end
  end

  // Control and status registers; full comes from the wrap-bit comparison.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      gcnt       <= '0;
      level      <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
      out_strobe <= 1'b0;
      out_reg    <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      gcnt       <= gcnt_nxt;
      level      <= LW'(wr_ptr_nxt - rd_ptr_nxt);
      full       <= (wr_ptr_nxt ^ rd_ptr_nxt) == {1'b1, {AW{1'b0}}};
      out_strobe <= pop;
      if (pop) begin
        out_reg <= mem[rd_ptr[AW-1:0]];
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage is not reset; only the pointers define valid entries.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sync_reg_pacer.sv
// Directed self-checking bench for sync_reg_pacer (WIDTH=4, DEPTH=4, GAP=8).
module tb_sync_reg_pacer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 8;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_stb;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             clr_ovf;
  logic             out_strobe;
  logic [WIDTH-1:0] out_reg;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int w      = 0;
  int scyc[$];
  logic [WIDTH-1:0] sdat[$];

  sync_reg_pacer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .wr_data(wr_data),
    .full(full), .level(level), .overflow(overflow), .clr_ovf(clr_ovf),
    .out_strobe(out_strobe), .out_reg(out_reg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log: edge count and data of every pulse
  always @(negedge clk) begin
    if (out_strobe === 1'b1) begin
      scyc.push_back(cyc);
      sdat.push_back(out_reg);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; wr_stb = 1'b0; clr_ovf = 1'b0; wr_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    scyc.delete(); sdat.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_stb = 1'b0; clr_ovf = 1'b0; wr_data = '0;
    tick(); tick();
    total++; if (out_strobe !== 1'b0) $display("FAIL reset_strobe got=%0h exp=0", out_strobe); else passed++;
    total++; if (out_reg !== 4'h0) $display("FAIL reset_out_reg got=%0h exp=0", out_reg); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got=%0h exp=0", full); else passed++;
    total++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%0h exp=0", overflow); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    wr_stb = 1'b1; wr_data = 4'h5;
    tick();
    wr_stb = 1'b0;
    total++; if (level !== 3'd1) $display("FAIL single_level_q got=%0d exp=1", level); else passed++;
    total++; if (out_strobe !== 1'b0) $display("FAIL single_early got=%0h exp=0", out_strobe); else passed++;
    tick();
    total++; if (out_strobe !== 1'b1) $display("FAIL single_strobe got=%0h exp=1", out_strobe); else passed++;
    total++; if (out_reg !== 4'h5) $display("FAIL single_data got=%0h exp=5", out_reg); else passed++;
    total++; if (level !== 3'd0) $display("FAIL single_level_e got=%0d exp=0", level); else passed++;
    tick();
    total++; if (out_strobe !== 1'b0) $display("FAIL single_pulse got=%0h exp=0", out_strobe); else passed++;
    total++; if (out_reg !== 4'h5) $display("FAIL single_hold got=%0h exp=5", out_reg); else passed++;
    repeat (10) tick();
  endtask

  task automatic test_burst;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_stb = 1'b1; wr_data = 4'(i + 1);
      tick();
      if (i == 0) w = cyc;
    end
    wr_stb = 1'b0;
    // first entry already popped one edge after the first write
    total++; if (level !== 3'd3) $display("FAIL burst_level got=%0d exp=3", level); else passed++;
    total++; if (full !== 1'b0) $display("FAIL burst_full got=%0h exp=0", full); else passed++;
    repeat (30) tick();
    total++; if (sdat.size() != 4) $display("FAIL burst_count got=%0d exp=4", sdat.size()); else passed++;
    for (int i = 0; i < sdat.size() && i < 4; i++) begin
      total++;
      if (sdat[i] !== 4'(i + 1) || scyc[i] != w + 1 + i * GAP)
        $display("FAIL burst_strobe%0d got=%0h@%0d exp=%0h@%0d", i, sdat[i], scyc[i], i + 1, w + 1 + i * GAP);
      else passed++;
    end
    total++; if (level !== 3'd0) $display("FAIL burst_drain got=%0d exp=0", level); else passed++;
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_stb = 1'b1; wr_data = 4'(i + 1);
      tick();
      if (i == 0) w = cyc;
    end
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set got=%0h exp=1", overflow); else passed++;
    total++; if (level !== 3'd4) $display("FAIL ovf_level got=%0d exp=4", level); else passed++;
    total++; if (full !== 1'b1) $display("FAIL ovf_full got=%0h exp=1", full); else passed++;
    wr_stb = 1'b1; wr_data = 4'h7; clr_ovf = 1'b1;
    tick();
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins got=%0h exp=1", overflow); else passed++;
    wr_stb = 1'b0;
    tick();
    clr_ovf = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got=%0h exp=0", overflow); else passed++;
    repeat (40) tick();
    total++; if (sdat.size() != 5) $display("FAIL ovf_count got=%0d exp=5", sdat.size()); else passed++;
    for (int i = 0; i < sdat.size() && i < 5; i++) begin
      total++;
      if (sdat[i] !== 4'(i + 1) || scyc[i] != w + 1 + i * GAP)
        $display("FAIL ovf_strobe%0d got=%0h@%0d exp=%0h@%0d", i, sdat[i], scyc[i], i + 1, w + 1 + i * GAP);
      else passed++;
    end
  endtask

  task automatic test_full_pop;
    logic [WIDTH-1:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_stb = 1'b1; wr_data = 4'(i + 1);
      tick();
    end
    wr_stb = 1'b0;
    total++; if (full !== 1'b1) $display("FAIL fp_full got=%0h exp=1", full); else passed++;
    repeat (4) tick();
    wr_stb = 1'b1; wr_data = 4'hA;
    tick();
    wr_stb = 1'b0;
    total++; if (out_strobe !== 1'b1 || out_reg !== 4'h2) $display("FAIL fp_pop got=%0h/%0h exp=1/2", out_strobe, out_reg); else passed++;
    total++; if (level !== 3'd4) $display("FAIL fp_level got=%0d exp=4", level); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL fp_ovf got=%0h exp=0", overflow); else passed++;
    repeat (40) tick();
    total++; if (sdat.size() != 6) $display("FAIL fp_count got=%0d exp=6", sdat.size()); else passed++;
    for (int i = 0; i < sdat.size() && i < 6; i++) begin
      e = (i < 5) ? 4'(i + 1) : 4'hA;
      total++;
      if (sdat[i] !== e) $display("FAIL fp_data%0d got=%0h exp=%0h", i, sdat[i], e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_stb = 1'b1; wr_data = 4'(i + 1);
      tick();
    end
    wr_stb = 1'b0;
    total++; if (level !== 3'd3) $display("FAIL rm_level_pre got=%0d exp=3", level); else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    scyc.delete(); sdat.delete();
    total++; if (level !== 3'd0 || full !== 1'b0) $display("FAIL rm_level got=%0d/%0h exp=0/0", level, full); else passed++;
    total++; if (out_reg !== 4'h0) $display("FAIL rm_out_reg got=%0h exp=0", out_reg); else passed++;
    tick();
    wr_stb = 1'b1; wr_data = 4'hC;
    tick();
    w = cyc;
    wr_stb = 1'b0;
    tick();
    total++; if (out_strobe !== 1'b1 || out_reg !== 4'hC) $display("FAIL rm_first got=%0h/%0h exp=1/c", out_strobe, out_reg); else passed++;
    repeat (30) tick();
    total++; if (sdat.size() != 1) $display("FAIL rm_count got=%0d exp=1", sdat.size()); else passed++;
    if (sdat.size() > 0) begin
      total++; if (scyc[0] != w + 1) $display("FAIL rm_cycle got=%0d exp=%0d", scyc[0], w + 1); else passed++;
    end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr_stb = 1'b1; wr_data = 4'((i * 5 + 3) % 16);
      tick();
      if (i == 0) w = cyc;
      wr_stb = 1'b0;
      repeat (GAP - 1) tick();
    end
    repeat (10) tick();
    total++; if (overflow !== 1'b0) $display("FAIL wrap_ovf got=%0h exp=0", overflow); else passed++;
    total++; if (sdat.size() != 20) $display("FAIL wrap_count got=%0d exp=20", sdat.size()); else passed++;
    for (int i = 0; i < sdat.size() && i < 20; i++) begin
      total++;
      if (sdat[i] !== 4'((i * 5 + 3) % 16) || scyc[i] != w + 1 + i * GAP)
        $display("FAIL wrap_strobe%0d got=%0h@%0d exp=%0h@%0d", i, sdat[i], scyc[i], (i * 5 + 3) % 16, w + 1 + i * GAP);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
